// File: rtl/alu_result_writeback.sv
// alu_result_writeback
//   EX->WB consumer of the ALU outputs. Each accepted op is registered and
//   turned into register-file writes through a single write port. MULT and
//   DIV produce two writes: ALU_Result to dest_addr, then Remainder to
//   REM_REG. An overflowing op never writes; it raises an exception instead.
//
// Configuration macro: ALU_OVF_TRAP_EN
//   defined   : EXC state plus exc_req/exc_ack handshake.
//   undefined : overflowed ops are dropped; exc_req is tied 0; exc_addr is a
//               sticky copy of the last overflowing dest_addr; exc_ack ignored.
//
// Ports
//   clk, rst       clock (rising edge), asynchronous active-high reset
//   in_valid       EX presents an op; in_ready high only in IDLE (comb.)
//   CTRL           op code; ALU_Result / Remainder / Overflow_flag operands
//   dest_addr      destination register of the op
//   wr_en/addr/data registered register-file write port (wr_en pulses)
//   exc_req        registered, level-held overflow exception request
//   exc_addr       dest_addr of the op that overflowed
//   exc_ack        exception acknowledge, only taken in EXC
//   dbg_state      current FSM state (0=IDLE, 1=WR_REM, 2=EXC)
//
// Handshake: an op transfers on the rising edge where in_valid && in_ready;
// all inputs are captured on that edge and ignored otherwise.

module alu_result_writeback #(
   parameter int DATA_W     = 16,
   parameter int REG_ADDR_W = 4,
   parameter int REM_REG    = 15
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [3:0]            CTRL,
   input  logic [DATA_W-1:0]     ALU_Result,
   input  logic [DATA_W-1:0]     Remainder,
   input  logic                  Overflow_flag,
   input  logic [REG_ADDR_W-1:0] dest_addr,
   output logic                  wr_en,
   output logic [REG_ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0]     wr_data,
   output logic                  exc_req,
   output logic [REG_ADDR_W-1:0] exc_addr,
   input  logic                  exc_ack,
   output logic [1:0]            dbg_state
);

`ifdef ALU_OVF_TRAP_EN
   typedef enum logic [1:0] {IDLE = 2'd0, WR_REM = 2'd1, EXC = 2'd2} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, WR_REM = 2'd1} state_t;
`endif

   localparam logic [REG_ADDR_W-1:0] REM_ADDR = REG_ADDR_W'(REM_REG);

   state_t                  state, state_n;
   logic                    wr_en_n;
   logic [REG_ADDR_W-1:0]   wr_addr_n, exc_addr_n;
   logic [DATA_W-1:0]       wr_data_n, rem_q, rem_n;
   logic                    exc_req_q, exc_req_n;
   logic                    accept, is_muldiv, is_alu, dest_ok;

   assign in_ready  = (state == IDLE);
   assign accept    = in_valid && in_ready;
   assign dbg_state = state;

   assign is_muldiv = (CTRL == 4'b0001) || (CTRL == 4'b0010);
   // 1000..1111 are the single-write ALU ops; everything else is NOP/HALT.
   assign is_alu    = CTRL[3];
   // R0 is read-only, so a write to it is suppressed.
   assign dest_ok   = (dest_addr != '0);

`ifdef ALU_OVF_TRAP_EN
   assign exc_req = exc_req_q;
`else
   logic unused_exc;
   assign exc_req    = 1'b0;
   assign unused_exc = exc_ack ^ exc_req_q;
`endif

   always_comb begin
      state_n    = state;
      wr_en_n    = 1'b0;
      wr_addr_n  = wr_addr;
      wr_data_n  = wr_data;
      exc_req_n  = exc_req_q;
      exc_addr_n = exc_addr;
      rem_n      = rem_q;
      case (state)
         IDLE: begin
            if (accept) begin
               rem_n = Remainder;
               if (Overflow_flag) begin
                  exc_addr_n = dest_addr;
`ifdef ALU_OVF_TRAP_EN
                  exc_req_n  = 1'b1;
                  state_n    = EXC;
`endif
               end else if (is_muldiv || is_alu) begin
                  if (is_muldiv) state_n = WR_REM;
                  if (dest_ok) begin
                     wr_en_n   = 1'b1;
                     wr_addr_n = dest_addr;
                     wr_data_n = ALU_Result;
                  end
               end
            end
         end
         WR_REM: begin
            // Remainder always written, even when the first write was suppressed.
            wr_en_n   = 1'b1;
            wr_addr_n = REM_ADDR;
            wr_data_n = rem_q;
            state_n   = IDLE;
         end
`ifdef ALU_OVF_TRAP_EN
         EXC: begin
            if (exc_ack) begin
               exc_req_n = 1'b0;
               state_n   = IDLE;
            end
         end
`endif
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         wr_en     <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         exc_req_q <= 1'b0;
         exc_addr  <= '0;
         rem_q     <= '0;
      end else begin
         state     <= state_n;
         wr_en     <= wr_en_n;
         wr_addr   <= wr_addr_n;
         wr_data   <= wr_data_n;
         exc_req_q <= exc_req_n;
         exc_addr  <= exc_addr_n;
         rem_q     <= rem_n;
      end
   end

endmodule
